// File: rtl/bram_pkg.sv
// Shared definitions for BRAM client blocks: reader FSM states and the
// read latency of the team's dual-port BRAM.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_e;

  localparam int BramReadLatency = 1;

endpackage

// File: rtl/bram_stream_reader_if.sv
// BRAM read port plus valid/ready output stream of the stream reader.
// master = the reader; slave = the BRAM model and downstream sink.
interface bram_stream_reader_if #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 11
);

  logic [AddrWidth-1:0] bram_addr_o;
  logic                 bram_write_en_o;
  logic [DataWidth-1:0] bram_data_o;
  logic [DataWidth-1:0] bram_data_i;
  logic [DataWidth-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_ready_i;

  modport master (
    output bram_addr_o, bram_write_en_o, bram_data_o, m_data_o, m_valid_o,
    input  bram_data_i, m_ready_i
  );

  modport slave (
    input  bram_addr_o, bram_write_en_o, bram_data_o, m_data_o, m_valid_o,
    output bram_data_i, m_ready_i
  );

endinterface

// File: rtl/fifo2_buffer.sv
// Two-entry register FIFO; the head word is a flop output so the stream
// data never depends combinationally on the consumer's ready.
module fifo2_buffer #(
  parameter int DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [1:0]           count_o,
  output logic [DataWidth-1:0] head_o
);

  logic [DataWidth-1:0] mem_q [2];
  logic [DataWidth-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive BRAM words and emits them as a valid/ready
// stream, hiding the one-cycle BRAM read latency behind a 2-entry buffer.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Depth     = 1024,
  parameter int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  bram_stream_reader_if.master bus
);

  localparam logic [AddrWidth-1:0] DepthLen = AddrWidth'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  reader_state_e        state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] remaining_q, remaining_d;
  logic                 inflight_q, inflight_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [AddrWidth-1:0] len_sat;
  logic [1:0]           count;
  logic [DataWidth-1:0] head;
  logic                 m_valid;
  logic                 pop;
  logic [2:0]           load;
  logic                 issue;

  assign len_sat = (length_i > DepthLen) ? DepthLen : length_i;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & bus.m_ready_i;

  // A slot is reserved for every in-flight read, so the buffer cannot overflow.
  assign load  = {1'b0, count} + {2'b00, inflight_q};
  assign issue = (state_q == READ) && (remaining_q != '0) &&
                 (load < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remaining_d = len_sat;
          state_d     = (len_sat == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          remaining_d = remaining_q - 1'b1;
          addr_d      = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
          if (remaining_q == AddrWidth'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fifo2_buffer #(
    .DataWidth (DataWidth)
  ) u_buffer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (inflight_q),
    .push_data_i (bus.bram_data_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign bus.bram_addr_o     = addr_q;
  assign bus.bram_write_en_o = 1'b0;
  assign bus.bram_data_o     = '0;
  assign bus.m_data_o        = head;
  assign bus.m_valid_o       = m_valid;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model preloaded with mem[i]=i&0xFF,
// table-driven and random transfers checked against a queue-based model.
module tb_bram_stream_reader;
  import bram_pkg::*;

  localparam int DataWidth = 8;
  localparam int Depth     = 1024;
  localparam int AddrWidth = $clog2(Depth + 1);
  localparam int Budget    = 4 * Depth + 100;

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b1;
  logic                 start      = 1'b0;
  logic [AddrWidth-1:0] base_addr  = '0;
  logic [AddrWidth-1:0] length     = '0;
  logic                 busy;
  logic                 done;

  bram_stream_reader_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus ();

  bram_stream_reader #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .length_i    (length),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [DataWidth-1:0] mem [Depth];

  always @(posedge clk) begin
    bus.bram_data_i <= mem[int'(bus.bram_addr_o) % Depth];
  end

  typedef struct {
    int base;
    int length;
    int mode;
    int exp_words;
    int exp_last_addr;
    int exp_done_cyc;
  } vec_t;

  vec_t vecs [7];

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DataWidth-1:0] got_q [$];
  logic [DataWidth-1:0] exp_q [$];

  int res_first_valid, res_done_cyc, res_done_pulses, res_busy_low;
  int res_timeout, res_max_out, res_stall_viol, res_busy_early, res_last_addr, res_wr_viol;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Expected stream: min(len, Depth) words starting at base, wrapping at Depth.
  task automatic buildExpected(input int b, input int len, output int n);
    n = (len > Depth) ? Depth : len;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % Depth]);
  endtask

  // Cycle index cyc counts edges after the edge that samples start.
  task automatic applyStimulus(input int b, input int len, input int mode);
    int cyc, issued, popped;
    logic prev_valid, prev_hs;
    logic [DataWidth-1:0] prev_data;
    logic [AddrWidth-1:0] last_seen;
    got_q.delete();
    res_first_valid = -1; res_done_cyc = -1; res_done_pulses = 0; res_busy_low = -1;
    res_timeout = 0; res_max_out = 0; res_stall_viol = 0; res_busy_early = 0;
    res_last_addr = 0; res_wr_viol = 0;
    @(negedge clk);
    start = 1'b1; base_addr = AddrWidth'(b); length = AddrWidth'(len);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; issued = 0; popped = 0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0; last_seen = AddrWidth'(b);
    forever begin
      bus.m_ready_i = ready_for(mode, cyc);
      @(negedge clk);
      if (bus.bram_addr_o != last_seen) begin
        issued++;
        last_seen = bus.bram_addr_o;
      end
      if (issued - popped > res_max_out) res_max_out = issued - popped;
      if (prev_valid && !prev_hs && (!bus.m_valid_o || bus.m_data_o !== prev_data)) res_stall_viol++;
      if (bus.bram_write_en_o !== 1'b0 || bus.bram_data_o !== '0) res_wr_viol++;
      if (bus.m_valid_o && res_first_valid < 0) res_first_valid = cyc;
      if (!busy && res_done_cyc < 0) res_busy_early++;
      if (done) begin
        res_done_pulses++;
        if (res_done_cyc < 0) res_done_cyc = cyc;
      end
      if (res_done_cyc >= 0 && cyc > res_done_cyc && !busy) begin
        res_busy_low  = cyc;
        res_last_addr = int'(bus.bram_addr_o);
        break;
      end
      prev_hs    = bus.m_valid_o && bus.m_ready_i;
      prev_valid = bus.m_valid_o;
      prev_data  = bus.m_data_o;
      if (prev_hs) begin
        got_q.push_back(bus.m_data_o);
        popped++;
      end
      if (cyc >= Budget) begin
        res_timeout = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.m_ready_i = 1'b0;
  endtask

  task automatic checkTransfer(input int b, input int len, input int mode,
                               input int exp_words, input int exp_last, input int exp_done);
    int n, nerr;
    applyStimulus(b, len, mode);
    buildExpected(b, len, n);
    nerr = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nerr++;
    checkOutput("timeout", res_timeout, 0);
    checkOutput("word_count", got_q.size(), exp_words);
    checkOutput("word_data_errors", nerr, 0);
    checkOutput("done_pulses", res_done_pulses, 1);
    checkOutput("busy_drop_cycle", res_busy_low, res_done_cyc + 1);
    checkOutput("busy_low_early", res_busy_early, 0);
    checkOutput("final_addr", res_last_addr, exp_last);
    checkOutput("outstanding_le_2", res_max_out <= 2, 1);
    checkOutput("stall_stability_errors", res_stall_viol, 0);
    checkOutput("write_port_nonzero", res_wr_viol, 0);
    if (exp_words > 0) checkOutput("first_valid_cycle", res_first_valid, 2);
    else               checkOutput("valid_never_seen", res_first_valid < 0, 1);
    if (exp_done >= 0) checkOutput("done_cycle", res_done_cyc, exp_done);
    $display("[TB] transfer base=%0d len=%0d mode=%0d words=%0d done_cyc=%0d",
             b, len, mode, got_q.size(), res_done_cyc);
  endtask

  initial begin
    int viol, rb, rl, rn;
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < Depth; i++) mem[i] = DataWidth'(i & 8'hFF);

    vecs[0] = '{base: 10,   length: 4,    mode: 0, exp_words: 4,    exp_last_addr: 14,  exp_done_cyc: 6};
    vecs[1] = '{base: 1022, length: 4,    mode: 0, exp_words: 4,    exp_last_addr: 2,   exp_done_cyc: 6};
    vecs[2] = '{base: 100,  length: 8,    mode: 1, exp_words: 8,    exp_last_addr: 108, exp_done_cyc: -1};
    vecs[3] = '{base: 0,    length: 0,    mode: 0, exp_words: 0,    exp_last_addr: 0,   exp_done_cyc: 0};
    vecs[4] = '{base: 500,  length: 2000, mode: 0, exp_words: 1024, exp_last_addr: 500, exp_done_cyc: 1026};
    vecs[5] = '{base: 1023, length: 1,    mode: 0, exp_words: 1,    exp_last_addr: 0,   exp_done_cyc: 3};
    vecs[6] = '{base: 3,    length: 1024, mode: 2, exp_words: 1024, exp_last_addr: 3,   exp_done_cyc: -1};

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_valid", bus.m_valid_o, 0);
    checkOutput("reset_data", bus.m_data_o, 0);
    checkOutput("reset_addr", bus.bram_addr_o, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_write_en", bus.bram_write_en_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Second start while busy must be ignored; then reset with words pending.
    @(negedge clk);
    start = 1'b1; base_addr = AddrWidth'(200); length = AddrWidth'(8);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; base_addr = AddrWidth'(700); length = AddrWidth'(3);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.m_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("held_first_valid", bus.m_valid_o, 1);
    checkOutput("held_first_word", bus.m_data_o, 200);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("second_word_in_order", bus.m_data_o, 201);
    @(posedge clk); #1 bus.m_ready_i = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", bus.m_valid_o, 0);
    checkOutput("midreset_data", bus.m_data_o, 0);
    checkOutput("midreset_addr", bus.bram_addr_o, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || bus.m_valid_o) viol++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || bus.m_valid_o) viol++;
    end
    checkOutput("quiet_after_reset", viol, 0);

    for (int v = 0; v < 7; v++)
      checkTransfer(vecs[v].base, vecs[v].length, vecs[v].mode,
                    vecs[v].exp_words, vecs[v].exp_last_addr, vecs[v].exp_done_cyc);

    for (int r = 0; r < 6; r++) begin
      rb = $urandom_range(0, Depth - 1);
      rl = (r == 5) ? 1100 : $urandom_range(0, 40);
      rn = (rl > Depth) ? Depth : rl;
      checkTransfer(rb, rl, 2, rn, (rb + rn) % Depth, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

- Read-side client for one port of the team's dual-port BRAM: on `start_i` it reads `length_i` consecutive words from `base_addr_i` and emits them as a valid/ready stream.
- Sits between a BRAM port (weights, activations, image buffers) and downstream compute, absorbing the 1-cycle BRAM read latency.
- Sustains one word per cycle under full-throughput backpressure via a 2-entry output buffer.

## Interface
Parameters:
- `DataWidth`, 8, word width; matches the BRAM port.
- `Depth`, 1024, BRAM depth in words.
- `AddrWidth`, `$clog2(Depth+1)`, address and length width; matches the BRAM port address width.

Ports:
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin a transfer; sampled only in IDLE.
- `base_addr_i`  in  AddrWidth  first word address; sampled with `start_i`; must be < Depth.
- `length_i`  in  AddrWidth  word count; sampled with `start_i`; values > Depth saturate to Depth.
- `busy_o`  out  1  high from the accepted start through the DONE state inclusive.
- `done_o`  out  1  one-cycle pulse when the transfer completes.
- `bram_addr_o`  out  AddrWidth  BRAM port address.
- `bram_write_en_o`  out  1  constant 0.
- `bram_data_o`  out  DataWidth  constant 0.
- `bram_data_i`  in  DataWidth  BRAM read data; valid the cycle after the address is presented.
- `m_data_o`  out  DataWidth  stream data.
- `m_valid_o`  out  1  stream valid.
- `m_ready_i`  in  1  stream ready.

## Operation
- Reset values: all outputs 0; state IDLE; buffer empty; `inflight` 0.
- **IDLE**
  - `start_i`=1: latch `base_addr_i` into the address counter and the saturated length into `remaining`.
  - Go to READ, or to DONE if length is 0.
- **READ**
  - A read issues when `remaining`>0 and (occupancy + inflight − pop) < 2, where pop = `m_valid_o & m_ready_i` in the same cycle.
  - On issue: `remaining`−1, address +1, and the address wraps from Depth−1 to 0.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN**: when inflight=0 and occupancy=0 (or the last word pops this cycle), go to DONE.
- **DONE**: `done_o`=1 for exactly one cycle, then IDLE.
- `bram_addr_o` is the address counter register, held when no read issues. Reads have no side effects, so this is harmless.
- `inflight` is a 1-bit register set on the cycle a read issues. At the next edge, `bram_data_i` is pushed into the buffer.
- Stream rules:
  - `m_data_o` is the buffer head.
  - Once asserted, `m_valid_o` and `m_data_o` stay stable until the handshake.
  - Words are emitted in address order.
- Boundary behaviour:
  - `start_i` outside IDLE is ignored.
  - Simultaneous push and pop keeps occupancy constant.
  - The buffer never overflows; the issue rule guarantees this.
  - Reset mid-transfer drops all buffered and in-flight data asynchronously, with no `done_o`.

## Timing
- E0 = edge sampling `start_i`.
- The first read address is presented in the cycle after E0.
- `m_valid_o` first rises after E0+2, i.e. 2-cycle start-to-first-word latency.
- With `m_ready_i` held 1: one word per cycle; the last word is valid after edge E0+1+N.
- `done_o` is high in the cycle after the edge on which the last word is accepted.
- For length 0: `done_o` is high in the cycle after E0.
- `busy_o` is registered: high the cycle after E0, low the cycle after `done_o`.
- No combinational path from `m_ready_i` to `m_valid_o` or `m_data_o`.
- `m_ready_i` does affect `bram_addr_o` advance through the issue rule; this combinational path is permitted.

## Structure
- Shared package `bram_pkg`:
  - `reader_state_e` enum: IDLE, READ, DRAIN, DONE.
  - BRAM read-latency constant `BramReadLatency` = 1.
- Sub-module `fifo2_buffer`: a 2-entry register FIFO with `push`/`pop`/`count` and head data.
- Control FSM, counters and issue logic stay in the top module.

## Test plan
- Memory preloaded with mem[i]=i&0xFF; base 10, length 4, `m_ready_i`=1 → words 10,11,12,13 on consecutive cycles; first valid 2 cycles after start; `done_o` one pulse.
- Base 1022, length 4, Depth 1024 → addresses 1022,1023,0,1 and the corresponding data in that order.
- Length 8 with `m_ready_i` toggling 1,0,0,1,… → all 8 words exactly once, in order; data stable while stalled; no more than 2 words buffered.
- Length 0 → no `m_valid_o`; `done_o` in the cycle after start; `busy_o` high for one cycle.
- `start_i` pulsed again mid-transfer, then `rst_n_i` asserted with 3 words pending → second start ignored; after reset all outputs 0, no `done_o`; a new transfer afterwards completes normally.
- Length 2000 → saturates to 1024 words, one pass of the full memory.
